// File: rtl/pipe_arb2.sv
// Two-requester arbiter feeding one shared output pipeline register.
// Round-robin on ties (pointer `last`), one-cycle acceptance-to-valid latency.
module pipe_arb2 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a0,
  input  logic             v0,
  output logic             r0,
  input  logic [WIDTH-1:0] a1,
  input  logic             v1,
  output logic             r1,
  input  logic             flush,
  output logic [WIDTH-1:0] b,
  output logic             bv,
  input  logic             br,
  output logic             bsrc
);

  logic [WIDTH-1:0] b_q, b_d;
  logic             bv_q, bv_d;
  logic             bsrc_q, bsrc_d;
  logic             last_q, last_d;

  logic open;
  logic grant0, grant1;

  // Register may take a new word when it is empty or being drained this cycle.
  assign open = ~flush & (~bv_q | br);

  // On a tie the requester not recorded in last wins.
  assign grant0 = v0 & (~v1 | last_q);
  assign grant1 = v1 & (~v0 | ~last_q);

  assign r0 = ~rst & open & grant0;
  assign r1 = ~rst & open & grant1;

  always_comb begin
    b_d    = b_q;
    bv_d   = bv_q;
    bsrc_d = bsrc_q;
    last_d = last_q;
    if (flush) begin
      bv_d = 1'b0;
    end else if (open) begin
      if (grant0) begin
        b_d    = a0;
        bsrc_d = 1'b0;
        bv_d   = 1'b1;
        last_d = 1'b0;
      end else if (grant1) begin
        b_d    = a1;
        bsrc_d = 1'b1;
        bv_d   = 1'b1;
        last_d = 1'b1;
      end else begin
        bv_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      b_q    <= '0;
      bv_q   <= 1'b0;
      bsrc_q <= 1'b0;
      last_q <= 1'b1;
    end else begin
      b_q    <= b_d;
      bv_q   <= bv_d;
      bsrc_q <= bsrc_d;
      last_q <= last_d;
    end
  end

  assign b    = b_q;
  assign bv   = bv_q;
  assign bsrc = bsrc_q;

endmodule

// File: tb/tb_pipe_arb2.sv
// Self-checking bench for pipe_arb2: directed scenarios plus randomized traffic
// compared against a transaction-level reference model.
module tb_pipe_arb2;

  localparam int unsigned W = 32;

  logic         clk;
  logic         rst;
  logic [W-1:0] a0, a1;
  logic         v0, v1;
  logic         r0, r1;
  logic         flush;
  logic [W-1:0] b;
  logic         bv;
  logic         br;
  logic         bsrc;

  int nchk;
  int nerr;

  // Reference model state: the held word and the tie-break memory.
  logic [W-1:0] m_b;
  logic         m_bv;
  logic         m_bsrc;
  int           m_last;

  pipe_arb2 #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .a0   (a0),
    .v0   (v0),
    .r0   (r0),
    .a1   (a1),
    .v1   (v1),
    .r1   (r1),
    .flush(flush),
    .b    (b),
    .bv   (bv),
    .br   (br),
    .bsrc (bsrc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Which requester (0/1) the model says is accepted this cycle, or -1.
  function automatic int model_winner();
    int req [$];
    if (rst || flush || (m_bv && !br)) return -1;
    if (v0) req.push_back(0);
    if (v1) req.push_back(1);
    if (req.size() == 0) return -1;
    if (req.size() == 1) return req[0];
    return 1 - m_last;
  endfunction

  task automatic drive(input logic r, input logic f, input logic vv0, input logic vv1,
                       input logic [W-1:0] d0, input logic [W-1:0] d1, input logic rdy);
    rst = r; flush = f; v0 = vv0; v1 = vv1; a0 = d0; a1 = d1; br = rdy;
    #1;
  endtask

  task automatic tick();
    int w;
    w = model_winner();
    @(posedge clk);
    #1;
    if (rst) begin
      m_b = '0; m_bv = 1'b0; m_bsrc = 1'b0; m_last = 1;
    end else if (w == 0) begin
      m_b = a0; m_bsrc = 1'b0; m_bv = 1'b1; m_last = 0;
    end else if (w == 1) begin
      m_b = a1; m_bsrc = 1'b1; m_bv = 1'b1; m_last = 1;
    end else if (flush || br) begin
      m_bv = 1'b0;
    end
  endtask

  task automatic test_reset();
    drive(1, 1, 1, 1, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1);
    nchk++;
    if (r0 !== 1'b0 || r1 !== 1'b0) begin
      nerr++; $display("FAIL reset_ready: r0=%b r1=%b required 0 0", r0, r1);
    end
    tick();
    tick();
    nchk++;
    if (bv !== 1'b0 || b !== '0 || bsrc !== 1'b0) begin
      nerr++; $display("FAIL reset_state: bv=%b b=%h bsrc=%b required 0 0 0", bv, b, bsrc);
    end
  endtask

  task automatic test_single();
    drive(0, 0, 1, 0, 32'h0000_00A5, 32'h0, 1);
    nchk++;
    if (r0 !== 1'b1 || r1 !== 1'b0) begin
      nerr++; $display("FAIL single_ready: r0=%b r1=%b required 1 0", r0, r1);
    end
    tick();
    drive(0, 0, 0, 0, 32'h0, 32'h0, 0);
    nchk++;
    if (bv !== 1'b1 || b !== 32'h0000_00A5 || bsrc !== 1'b0) begin
      nerr++; $display("FAIL single_out: bv=%b b=%h bsrc=%b required 1 000000a5 0", bv, b, bsrc);
    end
  endtask

  task automatic test_alternate();
    logic [W-1:0] eb [4];
    logic         es [4];
    eb = '{32'h1111_1111, 32'h2222_2222, 32'h1111_1111, 32'h2222_2222};
    es = '{1'b0, 1'b1, 1'b0, 1'b1};
    drive(1, 0, 0, 0, 32'h0, 32'h0, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 1, 32'h1111_1111, 32'h2222_2222, 1);
      nchk++;
      if (r0 !== ~es[i] || r1 !== es[i]) begin
        nerr++; $display("FAIL alt_ready[%0d]: r0=%b r1=%b required %b %b",
                         i, r0, r1, ~es[i], es[i]);
      end
      tick();
      nchk++;
      if (bv !== 1'b1 || b !== eb[i] || bsrc !== es[i]) begin
        nerr++; $display("FAIL alt_out[%0d]: bv=%b b=%h bsrc=%b required 1 %h %b",
                         i, bv, b, bsrc, eb[i], es[i]);
      end
    end
  endtask

  task automatic test_stall();
    drive(1, 0, 0, 0, 32'h0, 32'h0, 0);
    tick();
    drive(0, 0, 0, 1, 32'h0, 32'h2222_2222, 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 0, 32'h3333_3333, 32'h0, 0);
      nchk++;
      if (r0 !== 1'b0 || r1 !== 1'b0) begin
        nerr++; $display("FAIL stall_ready[%0d]: r0=%b r1=%b required 0 0", i, r0, r1);
      end
      tick();
      nchk++;
      if (bv !== 1'b1 || b !== 32'h2222_2222 || bsrc !== 1'b1) begin
        nerr++; $display("FAIL stall_hold[%0d]: bv=%b b=%h bsrc=%b required 1 22222222 1",
                         i, bv, b, bsrc);
      end
    end
    drive(0, 0, 1, 0, 32'h3333_3333, 32'h0, 1);
    nchk++;
    if (r0 !== 1'b1) begin
      nerr++; $display("FAIL stall_release: r0=%b required 1", r0);
    end
    tick();
    nchk++;
    if (b !== 32'h3333_3333 || bsrc !== 1'b0 || bv !== 1'b1) begin
      nerr++; $display("FAIL stall_next: b=%h bsrc=%b bv=%b required 33333333 0 1", b, bsrc, bv);
    end
  endtask

  // Entered with bv=1 and last=0 (requester 0 just accepted).
  task automatic test_flush();
    drive(0, 1, 0, 1, 32'h0, 32'h4444_4444, 1);
    nchk++;
    if (r1 !== 1'b0 || r0 !== 1'b0) begin
      nerr++; $display("FAIL flush_ready: r0=%b r1=%b required 0 0", r0, r1);
    end
    tick();
    nchk++;
    if (bv !== 1'b0 || b !== 32'h3333_3333) begin
      nerr++; $display("FAIL flush_out: bv=%b b=%h required 0 33333333", bv, b);
    end
    // Tie after the flush must still favour requester 1, proving last held at 0.
    drive(0, 0, 1, 1, 32'h5555_5555, 32'h4444_4444, 1);
    nchk++;
    if (r1 !== 1'b1 || r0 !== 1'b0) begin
      nerr++; $display("FAIL flush_after: r0=%b r1=%b required 0 1", r0, r1);
    end
    tick();
  endtask

  task automatic test_reset_stall();
    drive(0, 0, 1, 0, 32'h6666_6666, 32'h0, 1);
    tick();
    drive(0, 0, 1, 1, 32'h7777_7777, 32'h8888_8888, 0);
    tick();
    drive(1, 0, 1, 1, 32'h7777_7777, 32'h8888_8888, 0);
    tick();
    nchk++;
    if (bv !== 1'b0 || b !== '0 || bsrc !== 1'b0) begin
      nerr++; $display("FAIL rst_stall: bv=%b b=%h bsrc=%b required 0 0 0", bv, b, bsrc);
    end
    drive(0, 0, 1, 1, 32'h7777_7777, 32'h8888_8888, 0);
    nchk++;
    if (r0 !== 1'b1 || r1 !== 1'b0) begin
      nerr++; $display("FAIL rst_grant: r0=%b r1=%b required 1 0", r0, r1);
    end
    tick();
  endtask

  task automatic test_v1_streak();
    drive(1, 0, 0, 0, 32'h0, 32'h0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1, 32'h0, 32'h9000_0000 + i, 1);
      tick();
    end
    nchk++;
    if (b !== 32'h9000_0002 || bsrc !== 1'b1) begin
      nerr++; $display("FAIL streak_out: b=%h bsrc=%b required 90000002 1", b, bsrc);
    end
    drive(0, 0, 1, 1, 32'hA0A0_A0A0, 32'hB0B0_B0B0, 1);
    nchk++;
    if (r0 !== 1'b1 || r1 !== 1'b0) begin
      nerr++; $display("FAIL streak_grant: r0=%b r1=%b required 1 0", r0, r1);
    end
    tick();
  endtask

  task automatic test_random();
    int w;
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(31) == 0), ($urandom_range(7) == 0),
            $urandom_range(1), $urandom_range(1), $urandom, $urandom,
            ($urandom_range(3) != 0));
      w = model_winner();
      nchk++;
      if (r0 !== (w == 0) || r1 !== (w == 1)) begin
        nerr++; $display("FAIL rand_ready[%0d]: r0=%b r1=%b required %b %b",
                         i, r0, r1, (w == 0), (w == 1));
      end
      tick();
      nchk++;
      if (bv !== m_bv || bsrc !== m_bsrc || b !== m_b) begin
        nerr++; $display("FAIL rand_out[%0d]: bv=%b b=%h bsrc=%b required %b %h %b",
                         i, bv, b, bsrc, m_bv, m_b, m_bsrc);
      end
    end
  endtask

  initial begin
    nchk = 0;
    nerr = 0;
    m_b = '0; m_bv = 1'b0; m_bsrc = 1'b0; m_last = 1;
    rst = 1'b1; flush = 1'b0; v0 = 1'b0; v1 = 1'b0; a0 = '0; a1 = '0; br = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_alternate();
    test_stall();
    test_flush();
    test_reset_stall();
    test_v1_streak();
    test_random();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
